// File: rtl/pe_mac_engine_pkg.sv
// Shared widths, FSM encoding, issue-stage record and saturating add for the PE MAC engine.
// Optional zero-activation skipping is controlled by PE_ZERO_SKIP_EN in pe_mac_engine.sv.
package pe_mac_engine_pkg;

  localparam int ACT_WIDTH    = 16;
  localparam int INDEX_WIDTH  = 8;
  localparam int WEIGHT_WIDTH = 16;
  localparam int NUM_OUT      = 4;
  localparam int ACC_WIDTH    = 32;
  localparam int K_WIDTH      = $clog2(NUM_OUT);
  localparam int PROD_WIDTH   = ACT_WIDTH + WEIGHT_WIDTH;

  localparam logic [INDEX_WIDTH-1:0] END_TOKEN_INDEX = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [K_WIDTH-1:0]   k;
    logic [ACT_WIDTH-1:0] value;
  } issue_t;

  // One extra bit of headroom exposes signed overflow, which clamps instead of wrapping.
  function automatic logic [ACC_WIDTH-1:0] satAdd(input logic [ACC_WIDTH-1:0] acc,
                                                  input logic [PROD_WIDTH-1:0] prod);
    logic [ACC_WIDTH:0] sum;
    sum = {acc[ACC_WIDTH-1], acc}
        + {{(ACC_WIDTH + 1 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return sum[ACC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pe_mac_sat_acc.sv
// NUM_OUT-entry accumulator bank: saturating update of one entry per cycle,
// bulk clear, and combinational readout of the registered values.
module pe_mac_sat_acc
  import pe_mac_engine_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  updEn_i,
  input  logic [K_WIDTH-1:0]    updIdx_i,
  input  logic [PROD_WIDTH-1:0] prod_i,
  input  logic [K_WIDTH-1:0]    rdIdx_i,
  output logic [ACC_WIDTH-1:0]  rdData_o
);

  logic [ACC_WIDTH-1:0] acc_q [NUM_OUT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_OUT; i++) acc_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_OUT; i++) acc_q[i] <= '0;
    end else if (updEn_i) begin
      acc_q[updIdx_i] <= satAdd(acc_q[updIdx_i], prod_i);
    end
  end

  assign rdData_o = acc_q[rdIdx_i];

endmodule

// File: rtl/pe_mac_engine.sv
// PE MAC engine: pops activations, streams NUM_OUT weight reads per activation and
// accumulates signed products. Define PE_ZERO_SKIP_EN to discard zero-valued activations.
module pe_mac_engine
  import pe_mac_engine_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           queue_empty,
  input  logic [INDEX_WIDTH+ACT_WIDTH-1:0] act_in,
  output logic                           pop_act,
  output logic                           w_rd_en,
  output logic [INDEX_WIDTH+K_WIDTH-1:0] w_addr,
  input  logic [WEIGHT_WIDTH-1:0]        w_rd_data,
  input  logic                           acc_clear,
  input  logic [K_WIDTH-1:0]             acc_rd_idx,
  output logic [ACC_WIDTH-1:0]           acc_rd_data,
  output logic                           busy,
  output logic                           layer_done
);

  logic [1:0]             state_q, state_d;
  logic [K_WIDTH-1:0]     k_q, k_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [ACT_WIDTH-1:0]   val_q, val_d;
  issue_t                 issue_q, issue_d;

  logic [INDEX_WIDTH-1:0] headIdx;
  logic [ACT_WIDTH-1:0]   headVal;
  logic                   headIsEnd, headIsZero, kLast, pipeEmpty, takeHead, clearAcc;
  logic signed [PROD_WIDTH-1:0] actExt, wExt, prod;

  assign headIdx   = act_in[INDEX_WIDTH+ACT_WIDTH-1:ACT_WIDTH];
  assign headVal   = act_in[ACT_WIDTH-1:0];
  assign headIsEnd = (headIdx == END_TOKEN_INDEX);
`ifdef PE_ZERO_SKIP_EN
  assign headIsZero = (headVal == '0);
`else
  assign headIsZero = 1'b0;
`endif
  assign kLast     = (k_q == K_WIDTH'(NUM_OUT - 1));
  assign pipeEmpty = !issue_q.valid;

  // The next word is popped on the last MAC beat so consecutive activations run without bubbles.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    idx_d      = idx_q;
    val_d      = val_q;
    pop_act    = 1'b0;
    w_rd_en    = 1'b0;
    layer_done = 1'b0;
    clearAcc   = 1'b0;
    takeHead   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_clear) begin
          clearAcc = pipeEmpty;
        end else if (!queue_empty) begin
          takeHead = 1'b1;
        end
      end
      ST_MAC: begin
        w_rd_en = 1'b1;
        k_d     = k_q + 1'b1;
        if (kLast) begin
          if (!queue_empty) takeHead = 1'b1;
          else              state_d  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (pipeEmpty) begin
          layer_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (takeHead) begin
      pop_act = 1'b1;
      idx_d   = headIdx;
      val_d   = headVal;
      k_d     = '0;
      if (headIsEnd)       state_d = ST_DRAIN;
      else if (headIsZero) state_d = ST_IDLE;
      else                 state_d = ST_MAC;
    end
  end

  always_comb begin
    issue_d.valid = w_rd_en;
    issue_d.k     = k_q;
    issue_d.value = val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      issue_q <= issue_d;
    end
  end

  assign w_addr = {idx_q, k_q};
  assign busy   = (state_q != ST_IDLE) || issue_q.valid;

  // Weight data returns one cycle after issue, aligned with the issue-stage entry.
  assign actExt = PROD_WIDTH'($signed(issue_q.value));
  assign wExt   = PROD_WIDTH'($signed(w_rd_data));
  assign prod   = actExt * wExt;

  pe_mac_sat_acc u_acc (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (clearAcc),
    .updEn_i  (issue_q.valid),
    .updIdx_i (issue_q.k),
    .prod_i   (prod),
    .rdIdx_i  (acc_rd_idx),
    .rdData_o (acc_rd_data)
  );

endmodule

// File: tb/tb_pe_mac_engine.sv
// Directed testbench for pe_mac_engine with an activation-queue model, weight SRAM model
// and scoreboards for weight addresses and end-of-layer accumulator contents.
module tb_pe_mac_engine;
  import pe_mac_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        queue_empty;
  logic [23:0] act_in;
  logic        pop_act;
  logic        w_rd_en;
  logic [9:0]  w_addr;
  logic [15:0] w_rd_data = '0;
  logic        acc_clear;
  logic [1:0]  acc_rd_idx;
  logic [31:0] acc_rd_data;
  logic        busy;
  logic        layer_done;

  pe_mac_engine dut (
    .clk         (clk),
    .rst         (rst),
    .queue_empty (queue_empty),
    .act_in      (act_in),
    .pop_act     (pop_act),
    .w_rd_en     (w_rd_en),
    .w_addr      (w_addr),
    .w_rd_data   (w_rd_data),
    .acc_clear   (acc_clear),
    .acc_rd_idx  (acc_rd_idx),
    .acc_rd_data (acc_rd_data),
    .busy        (busy),
    .layer_done  (layer_done)
  );

  always #10 clk = ~clk;

  logic [15:0] wMem [0:1023];

  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wMem[w_addr];
  end

  logic [23:0] actQ[$];
  logic [9:0]  expAddrQ[$];
  logic [31:0] expAccQ[$];
  int          popCycles[$];
  logic [31:0] expAcc [4];

  int passCount = 0;
  int totalCount = 0;
  int cycle = 0;
  int wrCount, firstWr, lastWr, doneCount, doneCycle, busyFall;
  logic prevBusy = 1'b0;
  int cA;
  logic [31:0] rdVal;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] modelSat(input logic [31:0] a, input longint p);
    longint s;
    longint maxV = 64'sd2147483647;
    longint minV = -64'sd2147483648;
    s = longint'($signed(a)) + p;
    if (s > maxV) s = maxV;
    else if (s < minV) s = minV;
    return s[31:0];
  endfunction

  task automatic refreshQ();
    queue_empty = (actQ.size() == 0);
    if (actQ.size() > 0) act_in = actQ[0];
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input logic [15:0] val);
    logic skip;
    actQ.push_back({idx, val});
    if (idx == 8'hFF) begin
      for (int k = 0; k < 4; k++) expAccQ.push_back(expAcc[k]);
    end else begin
      skip = 1'b0;
`ifdef PE_ZERO_SKIP_EN
      skip = (val == 16'd0);
`endif
      if (!skip) begin
        for (int k = 0; k < 4; k++) begin
          logic [9:0] a;
          a = {idx, 2'(k)};
          expAddrQ.push_back(a);
          expAcc[k] = modelSat(expAcc[k], longint'($signed(val)) * longint'($signed(wMem[a])));
        end
      end
    end
    refreshQ();
  endtask

  task automatic readAcc(input int k, output logic [31:0] v);
    acc_rd_idx = 2'(k);
    #1;
    v = acc_rd_data;
  endtask

  task automatic clearModel();
    for (int k = 0; k < 4; k++) expAcc[k] = '0;
  endtask

  task automatic clearStats();
    wrCount = 0; firstWr = -1; lastWr = -1;
    doneCount = 0; doneCycle = -1; busyFall = -1;
    popCycles.delete();
  endtask

  // One clock: sample outputs mid-cycle, score them, then consume a popped word after the edge.
  task automatic step();
    logic        sPop, sWr, sDone, sBusy;
    logic [9:0]  sAddr;
    logic [31:0] v;
    @(negedge clk);
    sPop = pop_act; sWr = w_rd_en; sAddr = w_addr; sDone = layer_done; sBusy = busy;
    if (sWr) begin
      wrCount++;
      if (firstWr < 0) firstWr = cycle;
      lastWr = cycle;
      checkOutput("rd_expected", 32'(expAddrQ.size() > 0), 1);
      if (expAddrQ.size() > 0) checkOutput("w_addr", 32'(sAddr), 32'(expAddrQ.pop_front()));
    end
    if (sPop) begin
      popCycles.push_back(cycle);
      checkOutput("pop_nonempty", 32'(actQ.size() > 0), 1);
    end
    if (sDone) begin
      doneCount++;
      doneCycle = cycle;
      checkOutput("done_expected", 32'(expAccQ.size() >= 4), 1);
      if (expAccQ.size() >= 4) begin
        for (int k = 0; k < 4; k++) begin
          readAcc(k, v);
          checkOutput($sformatf("acc%0d_at_done", k), v, expAccQ.pop_front());
        end
      end
    end
    if (prevBusy && !sBusy) busyFall = cycle;
    prevBusy = sBusy;
    @(posedge clk);
    #1;
    if (sPop && actQ.size() > 0) void'(actQ.pop_front());
    cycle++;
    refreshQ();
  endtask

  task automatic runCycles(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; queue_empty = 1'b1; act_in = '0; acc_clear = 1'b0; acc_rd_idx = '0;
    for (int i = 0; i < 1024; i++) wMem[i] = '0;
    clearModel();
    clearStats();
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("rst_pop", 32'(pop_act), 0);
    checkOutput("rst_wr", 32'(w_rd_en), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(layer_done), 0);
    for (int k = 0; k < 4; k++) begin
      readAcc(k, rdVal);
      checkOutput($sformatf("rst_acc%0d", k), rdVal, 0);
    end
    rst = 1'b0;

    $display("[TB] single activation then end token");
    wMem[12] = 16'd1; wMem[13] = 16'd2; wMem[14] = 16'd3; wMem[15] = 16'hFFFC;
    clearStats();
    applyStimulus(8'd3, 16'd2);
    applyStimulus(8'hFF, 16'd0);
    runCycles(12);
    checkOutput("t1_wr_count", 32'(wrCount), 4);
    checkOutput("t1_wr_span", 32'(lastWr - firstWr), 3);
    checkOutput("t1_done_count", 32'(doneCount), 1);
    checkOutput("t1_done_delay", 32'(doneCycle - lastWr), 2);
    checkOutput("t1_busy_fall", 32'(busyFall - doneCycle), 1);
    readAcc(3, rdVal);
    checkOutput("t1_acc3", rdVal, 32'hFFFF_FFF8);

    $display("[TB] two back-to-back activations");
    acc_clear = 1'b1; clearModel();
    step();
    acc_clear = 1'b0;
    wMem[4] = 16'd5;   wMem[5] = 16'hFFFA; wMem[6] = 16'd7;    wMem[7] = 16'd8;
    wMem[8] = 16'd100; wMem[9] = 16'd200;  wMem[10] = 16'hFED4; wMem[11] = 16'd400;
    clearStats();
    applyStimulus(8'd1, 16'd1);
    applyStimulus(8'd2, 16'hFFFF);
    applyStimulus(8'hFF, 16'd0);
    runCycles(16);
    checkOutput("t2_pop_count", 32'(popCycles.size()), 3);
    if (popCycles.size() == 3) begin
      checkOutput("t2_pop_gap1", 32'(popCycles[1] - popCycles[0]), 4);
      checkOutput("t2_pop_gap2", 32'(popCycles[2] - popCycles[1]), 4);
    end
    checkOutput("t2_wr_count", 32'(wrCount), 8);
    checkOutput("t2_wr_span", 32'(lastWr - firstWr), 7);
    checkOutput("t2_done_count", 32'(doneCount), 1);

    $display("[TB] saturation");
    acc_clear = 1'b1; clearModel();
    step();
    acc_clear = 1'b0;
    wMem[40] = 16'h7FFF; wMem[41] = 16'h8000; wMem[42] = 16'd0; wMem[43] = 16'd0;
    wMem[44] = 16'd9361; wMem[45] = 16'd0;    wMem[46] = 16'd0; wMem[47] = 16'd0;
    wMem[48] = 16'd1;    wMem[49] = 16'h8000; wMem[50] = 16'd0; wMem[51] = 16'd0;
    clearStats();
    applyStimulus(8'd10, 16'h7FFF);
    applyStimulus(8'd10, 16'h7FFF);
    applyStimulus(8'd11, 16'd14);
    applyStimulus(8'd12, 16'h0100);
    applyStimulus(8'hFF, 16'd0);
    runCycles(30);
    readAcc(0, rdVal);
    checkOutput("t3_acc0_max", rdVal, 32'h7FFF_FFFF);
    readAcc(1, rdVal);
    checkOutput("t3_acc1_min", rdVal, 32'h8000_0000);
    checkOutput("t3_done_count", 32'(doneCount), 1);

    $display("[TB] acc_clear priority and clear during MAC");
    clearStats();
    acc_clear = 1'b1; clearModel();
    applyStimulus(8'd3, 16'd1);
    cA = cycle;
    step();
    acc_clear = 1'b0;
    checkOutput("t4_no_pop_on_clear", 32'(popCycles.size()), 0);
    for (int k = 0; k < 4; k++) begin
      readAcc(k, rdVal);
      checkOutput($sformatf("t4_acc%0d_cleared", k), rdVal, 0);
    end
    step();
    checkOutput("t4_pop_count", 32'(popCycles.size()), 1);
    if (popCycles.size() == 1) checkOutput("t4_pop_deferred", 32'(popCycles[0] - cA), 1);
    step();
    acc_clear = 1'b1;
    checkOutput("t4_busy_in_mac", 32'(busy), 1);
    step();
    acc_clear = 1'b0;
    applyStimulus(8'hFF, 16'd0);
    runCycles(12);
    readAcc(3, rdVal);
    checkOutput("t4_acc3_kept", rdVal, 32'hFFFF_FFFC);

    $display("[TB] reset mid-MAC");
    clearStats();
    applyStimulus(8'd3, 16'd5);
    runCycles(3);
    rst = 1'b1;
    #1;
    checkOutput("t5_pop", 32'(pop_act), 0);
    checkOutput("t5_wr", 32'(w_rd_en), 0);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_done", 32'(layer_done), 0);
    checkOutput("t5_wr_before", 32'(wrCount), 2);
    for (int k = 0; k < 4; k++) begin
      readAcc(k, rdVal);
      checkOutput($sformatf("t5_acc%0d_reset", k), rdVal, 0);
    end
    expAddrQ.delete();
    clearModel();
    step();
    rst = 1'b0;
    clearStats();
    wMem[20] = 16'd7; wMem[21] = 16'd7; wMem[22] = 16'd7; wMem[23] = 16'd7;
    applyStimulus(8'd2, 16'd3);
    applyStimulus(8'd5, 16'd0);
    applyStimulus(8'hFF, 16'd0);
    runCycles(20);
`ifdef PE_ZERO_SKIP_EN
    checkOutput("t5_wr_count", 32'(wrCount), 4);
`else
    checkOutput("t5_wr_count", 32'(wrCount), 8);
`endif
    checkOutput("t5_done_count", 32'(doneCount), 1);

    checkOutput("addr_queue_drained", 32'(expAddrQ.size()), 0);
    checkOutput("acc_queue_drained", 32'(expAccQ.size()), 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
